sync_fifo_flags: RTL

Parametrised single-clock FIFO, successor to the team's fixed 8×16 `sync_fifo`. It generalises width and depth and adds occupancy count and programmable almost-full/almost-empty thresholds. It also adds sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer datapath stages in the same clock domain as the buffering primitive.

---
 rtl/sync_fifo_flags.sv | 115 +++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] din,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    input  logic              flush,
    input  logic              err_clr,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic full_w, empty_w, wa, ra;

    // Depth need not be a power of two, so wrap with an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign wa      = wr_en & (~full_w | rd_en);
    assign ra      = rd_en & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wa) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (ra) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(wa) - CW'(ra);
        end
    end

    // A new error event beats err_clr in the same cycle; flushed requests raise nothing.
    always_comb begin
        ovf_d = (~flush & wr_en & full_w & ~rd_en) | (ovf_q & ~err_clr);
        udf_d = (~flush & rd_en & empty_w) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wa && !flush) mem[wr_ptr_q] <= din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = mem[rd_ptr_q];
`else
    logic [DWIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= '0;
        end else if (ra && !flush) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign dout = dout_q;
`endif

    assign count        = count_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
